w_stream_gen: RTL and testbench

Serial bit-stream generator that produces the single-bit `w` stimulus consumed by the team's FSM sequence detectors. It replaces hand-written per-cycle `w` assignments with a loadable pattern engine. It captures a parallel pattern, a bit length and a repeat count on a `start` strobe. It then shifts the pattern out MSB-first, one bit per clock, with a valid qualifier and a completion pulse.

---
 rtl/w_stream_pkg.sv | 16 +
 rtl/w_stream_shreg.sv | 42 ++++
 rtl/w_stream_gen.sv | 140 ++++++++++++++
 tb/tb_w_stream_gen.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/w_stream_pkg.sv
// w_stream_gen shared types and default constants.
// Gap feature: W_STREAM_GEN_GAP_EN.
package w_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP,
    DONE
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 4;
  localparam int DEF_GAP   = 2;

endpackage

// File: rtl/w_stream_shreg.sv
// Loadable left-shift window with bit counter for w_stream_gen.
// Pattern is left-aligned on load so the MSB is always the next bit.
module w_stream_shreg
  import w_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_pat,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_msb,
  output logic             o_last
);

  logic [WIDTH-1:0] r_win;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] w_sh;

  assign w_sh = LEN_W'(WIDTH) - i_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_win <= i_pat << w_sh;
      r_cnt <= i_len;
    end else if (i_shift) begin
      r_win <= {r_win[WIDTH-2:0], 1'b0};
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_msb = r_win[WIDTH-1];
  // counter reaches zero with the current shift
  assign o_last = (r_cnt == LEN_W'(1));

endmodule

// File: rtl/w_stream_gen.sv
// Serial w bit-stream generator: pattern x passes, MSB first.
// Define W_STREAM_GEN_GAP_EN for idle gaps between passes.
module w_stream_gen
  import w_stream_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int LEN_W      = $clog2(WIDTH) + 1,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int GAP_CYCLES = DEF_GAP
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [CNT_W-1:0] reps,
  output logic             w,
  output logic             w_valid,
  output logic             busy,
  output logic             done
);

  state_t           r_state;
  logic [WIDTH-1:0] r_pat;
  logic [LEN_W-1:0] r_len;
  logic [CNT_W-1:0] r_pass;
  logic             r_w;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;
`ifdef W_STREAM_GEN_GAP_EN
  logic [3:0]       r_gap;
`endif

  logic [LEN_W-1:0] w_len_c;
  logic             w_idle;
  logic             w_shift;
  logic             w_reload;
  logic             w_load;
  logic [WIDTH-1:0] w_ld_pat;
  logic [LEN_W-1:0] w_ld_len;
  logic             w_msb;
  logic             w_last;

  assign w_len_c = (len > LEN_W'(WIDTH))
                 ? LEN_W'(WIDTH) : len;

  assign w_idle   = (r_state == IDLE);
  assign w_shift  = (r_state == SHIFT);
  assign w_reload = w_shift && w_last
                 && (r_pass != '0);
  assign w_load   = (w_idle && start) || w_reload;
  assign w_ld_pat = w_idle ? pattern : r_pat;
  assign w_ld_len = w_idle ? w_len_c : r_len;

  w_stream_shreg #(
    .WIDTH (WIDTH),
    .LEN_W (LEN_W)
  ) u_shreg (
    .clk     (Clock),
    .rst_n   (Resetn),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_pat   (w_ld_pat),
    .i_len   (w_ld_len),
    .o_msb   (w_msb),
    .o_last  (w_last)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= IDLE;
      r_pat   <= '0;
      r_len   <= '0;
      r_pass  <= '0;
      r_w     <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef W_STREAM_GEN_GAP_EN
      r_gap   <= '0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          r_w     <= 1'b0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          if (start) begin
            r_pat   <= pattern;
            r_len   <= w_len_c;
            r_pass  <= reps;
            r_state <= (w_len_c == '0)
                     ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          r_w     <= w_msb;
          r_valid <= 1'b1;
          r_busy  <= 1'b1;
          if (w_last) begin
            if (r_pass != '0) begin
              r_pass <= r_pass - 1'b1;
`ifdef W_STREAM_GEN_GAP_EN
              r_gap   <= 4'(GAP_CYCLES);
              r_state <= GAP;
`endif
            end else begin
              r_state <= DONE;
            end
          end
        end
`ifdef W_STREAM_GEN_GAP_EN
        GAP: begin
          r_w     <= 1'b0;
          r_valid <= 1'b0;
          r_gap   <= r_gap - 1'b1;
          if (r_gap == 4'd1) r_state <= SHIFT;
        end
`endif
        DONE: begin
          // first edge raises done, second returns to IDLE
          r_w     <= 1'b0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= !r_done;
          if (r_done) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w       = r_w;
  assign w_valid = r_valid;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_w_stream_gen.sv
// Directed table-driven bench for w_stream_gen.
// Works with or without W_STREAM_GEN_GAP_EN.
module tb_w_stream_gen;

  localparam int WIDTH = 16;
  localparam int LEN_W = 5;
  localparam int CNT_W = 4;
  localparam int GAPC  = 2;
`ifdef W_STREAM_GEN_GAP_EN
  localparam int G = GAPC;
`else
  localparam int G = 0;
`endif

  logic             Clock;
  logic             Resetn;
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [CNT_W-1:0] reps;
  logic             w;
  logic             w_valid;
  logic             busy;
  logic             done;

  int n_assert;
  int n_fail;

  w_stream_gen #(
    .WIDTH      (WIDTH),
    .LEN_W      (LEN_W),
    .CNT_W      (CNT_W),
    .GAP_CYCLES (GAPC)
  ) dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .start   (start),
    .pattern (pattern),
    .len     (len),
    .reps    (reps),
    .w       (w),
    .w_valid (w_valid),
    .busy    (busy),
    .done    (done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [15:0] pat;
    logic [4:0]  len;
    logic [3:0]  reps;
    logic        glitch;
    logic [63:0] bits;
    int          n;
    int          gaps;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic outs_zero(input string name);
    chk(name, 64'({w, w_valid, busy, done}), 64'd0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [63:0] got;
    int nval, nbusy, nidle, wbad, first, done_c;
    int exp_done;
    string t;
    t = $sformatf("v%0d", idx);
    exp_done = v.n + v.gaps * G + 1;
    got = '0; nval = 0; nbusy = 0; nidle = 0;
    wbad = 0; first = 0; done_c = 0;
    @(negedge Clock);
    pattern = v.pat; len = v.len; reps = v.reps;
    start = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0;
    pattern = ~v.pat; len = 5'd7; reps = 4'd9;
    for (int c = 1; c <= 400 && done_c == 0; c++) begin
      start = v.glitch && (c == 2);
      @(posedge Clock); #1;
      if (busy) nbusy++;
      if (busy && !w_valid) nidle++;
      if (w_valid) begin
        got = {got[62:0], w};
        nval++;
        if (first == 0) first = c;
      end else if (w) begin
        wbad++;
      end
      if (done) done_c = c;
    end
    start = 1'b0;
    if (done_c == 0) begin
      n_assert++; n_fail++;
      $display("FAIL %s_timeout: got no done expected done", t);
      return;
    end
    chk({t, "_done_cyc"}, 64'(done_c), 64'(exp_done));
    chk({t, "_nbits"}, 64'(nval), 64'(v.n));
    chk({t, "_bits"}, got, v.bits);
    chk({t, "_busy_cyc"}, 64'(nbusy), 64'(exp_done - 1));
    chk({t, "_gap_idle"}, 64'(nidle), 64'(v.gaps * G));
    chk({t, "_w_when_invalid"}, 64'(wbad), 64'd0);
    if (v.n > 0) chk({t, "_first"}, 64'(first), 64'd1);
    chk({t, "_done_outs"}, 64'({w_valid, busy}), 64'd0);
    // start in the done cycle must be ignored
    pattern = 16'h000F; len = 5'd4; reps = 4'd0;
    start = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0;
    chk({t, "_done_pulse"}, 64'(done), 64'd0);
    @(posedge Clock); #1;
    chk({t, "_start_in_done"},
        64'({busy, w_valid}), 64'd0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    vecs[0] = '{16'h000B, 5'd4, 4'd0, 1'b0,
                64'hB, 4, 0};
    vecs[1] = '{16'h0006, 5'd3, 4'd2, 1'b0,
                64'h1B6, 9, 2};
    vecs[2] = '{16'hFFFF, 5'd0, 4'd3, 1'b0,
                64'h0, 0, 0};
    vecs[3] = '{16'hA5C3, 5'd20, 4'd0, 1'b0,
                64'hA5C3, 16, 0};
    vecs[4] = '{16'h0002, 5'd2, 4'd15, 1'b0,
                64'hAAAA_AAAA, 32, 15};
    vecs[5] = '{16'h8001, 5'd16, 4'd1, 1'b0,
                64'h8001_8001, 32, 1};
    vecs[6] = '{16'hFFF1, 5'd1, 4'd0, 1'b0,
                64'h1, 1, 0};
    vecs[7] = '{16'h000B, 5'd4, 4'd0, 1'b1,
                64'hB, 4, 0};

    Resetn = 1'b0; start = 1'b1;
    pattern = 16'hFFFF; len = 5'd4; reps = 4'd1;
    @(posedge Clock); #1;
    outs_zero("reset_c1");
    @(posedge Clock); #1;
    outs_zero("reset_c2");
    start = 1'b0;
    @(negedge Clock);
    Resetn = 1'b1;
    @(posedge Clock); #1;
    outs_zero("after_release");

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // abort after the 2nd bit of a 4-bit run
    @(negedge Clock);
    pattern = 16'h000B; len = 5'd4; reps = 4'd0;
    start = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0;
    @(posedge Clock); #1;
    chk("abort_bit1", 64'({w_valid, w}), 64'b11);
    @(posedge Clock); #1;
    chk("abort_bit2", 64'({w_valid, w}), 64'b10);
    #2 Resetn = 1'b0;
    #1 outs_zero("abort_async");
    @(posedge Clock); #1;
    outs_zero("abort_hold");
    @(negedge Clock);
    Resetn = 1'b1;
    @(posedge Clock); #1;
    outs_zero("abort_release");
    run_vec(8, vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
